image_pass_scheduler: RTL
=========================

IMAGE_PASS_SCHEDULER -- requirements
Module: image_pass_scheduler

Interface
REQ-001 The block SHALL have parameter HSIZE, default 512: pixels per line.
REQ-002 The block SHALL have parameter VSIZE, default 424: lines per frame.
REQ-003 The block SHALL have parameter MAX_BLOB_PASSES, default 20: maximum blob passes per frame.
REQ-004 The block SHALL have port clock, input, 1 bit: sole clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port frame_available, input, 1 bit: one-cycle pulse, new camera frame present.
REQ-007 The block SHALL have port blob_valid, input, 1 bit: datapath verdict on the current blob, sampled only in the last cycle of a blob pass.
REQ-008 The block SHALL have port pass_kind, output, 3 bits: 0 IDLE, 1 LOAD, 2 ERODE, 3 DILATE, 4 BLOB.
REQ-009 The block SHALL have port hcount, output, 10 bits: current pixel column.
REQ-010 The block SHALL have port vcount, output, 10 bits: current pixel row.
REQ-011 The block SHALL have port pass_start, output, 1 bit: high in the first pixel cycle of every pass.
REQ-012 The block SHALL have port pass_done, output, 1 bit: high in the last pixel cycle of every pass.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any non-IDLE state.
REQ-014 The block SHALL have port blob_count, output, 6 bits: blob passes completed in this frame.
REQ-015 The block SHALL have port touch, output, 1 bit: result of the last finished frame.
REQ-016 The block SHALL have port touch_ready, output, 1 bit: one-cycle pulse, touch updated.
REQ-017 The block SHALL have port frame_dropped, output, 1 bit: one-cycle pulse, a frame request was discarded.

Function
REQ-018 States SHALL be IDLE, LOAD, ERODE, DILATE and BLOB; pass_kind SHALL equal the state encoding.
REQ-019 Each pass SHALL visit HSIZE*VSIZE pixels, one per cycle, hcount fastest: hcount 0..HSIZE-1, then vcount+1; both SHALL be 0 in the pass_start cycle.
REQ-020 At (HSIZE-1, VSIZE-1), pass_done SHALL be 1; the next cycle SHALL be pixel (0,0) of the next pass or IDLE, with no gap cycles.
REQ-021 From IDLE: frame_available, or a pending request, SHALL enter LOAD the next cycle. The pending flag SHALL clear on entry.
REQ-022 The pass order SHALL be LOAD -> ERODE -> DILATE -> BLOB.
REQ-023 At the end of a BLOB pass, blob_count SHALL increment (saturating at 63).
REQ-024 If blob_valid=1 at BLOB pass_done, the next cycle SHALL set touch=1, pulse touch_ready, and enter IDLE.
REQ-025 Else, if the incremented count is below MAX_BLOB_PASSES, the block SHALL rerun BLOB with counters at (0,0).
REQ-026 Else the block SHALL set touch=0, pulse touch_ready, and enter IDLE.
REQ-027 blob_count SHALL reset to 0 on LOAD entry; it SHALL hold its value in IDLE.
REQ-028 frame_available while busy SHALL set a one-deep pending flag; if the flag is already set, frame_dropped SHALL pulse in that same cycle.
REQ-029 frame_available in the cycle touch_ready pulses SHALL enter LOAD directly on the next cycle (treated as IDLE arrival).
REQ-030 In IDLE, hcount, vcount, pass_start and pass_done SHALL be 0.
REQ-031 Counters SHALL be 10-bit unsigned; HSIZE and VSIZE SHALL each be at most 1024.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE and 0 on every output and internal register (pending flag included), regardless of state.
REQ-033 After reset_n deasserts, the first accepted frame_available SHALL start LOAD on the following cycle.

Structure
REQ-034 State encodings and pass_kind constants SHALL live in a shared package used by the scheduler and the datapath.
REQ-035 The scan counter (hcount/vcount with last-pixel detect) SHALL be one sub-module, pixel_scan_counter, instantiated once.

Verification (bench parameters: HSIZE=8, VSIZE=4, MAX_BLOB_PASSES=3; 32 cycles per pass)
REQ-036 Valid blob: frame_available at cycle 0 and blob_valid=1 at the first BLOB done -> LOAD starts cycle 1; touch_ready at cycle 129 with touch=1; blob_count=1.
REQ-037 No blob: blob_valid always 0 -> three BLOB passes; touch_ready at cycle 193 with touch=0; blob_count=3.
REQ-038 Overrun: two frame_available pulses during ERODE -> the second pulses frame_dropped; a new LOAD starts the cycle after touch_ready.
REQ-039 Back-to-back: frame_available coincident with touch_ready -> LOAD pass_start on the next cycle.
REQ-040 Mid-pass reset: reset_n low during DILATE at pixel (3,2) -> all outputs 0 in the same cycle; stays IDLE until a new frame_available.
REQ-041 Scan order: every pass checks that (hcount,vcount) goes (0,0),(1,0)...(7,0),(0,1)...(7,3), with pass_start and pass_done asserted only at the endpoints.

Source files
------------

// File: rtl/image_pass_scheduler_pkg.sv
// Shared definitions for the image pass scheduler and the image datapath.
//   pass_kind_e     : scheduler state, doubles as the pass_kind output code
//   SCAN_W          : width of the hcount/vcount scan counters
//   BLOB_COUNT_W    : width of the per-frame blob pass counter
//   blob_count_inc  : saturating increment for the blob pass counter
package image_pass_scheduler_pkg;

    typedef enum logic [2:0] {
        PASS_IDLE   = 3'd0,
        PASS_LOAD   = 3'd1,
        PASS_ERODE  = 3'd2,
        PASS_DILATE = 3'd3,
        PASS_BLOB   = 3'd4
    } pass_kind_e;

    localparam int SCAN_W       = 10;
    localparam int BLOB_COUNT_W = 6;

    localparam logic [BLOB_COUNT_W-1:0] BLOB_COUNT_MAX = '1;

    function automatic logic [BLOB_COUNT_W-1:0] blob_count_inc(
        input logic [BLOB_COUNT_W-1:0] value
    );
        return (value == BLOB_COUNT_MAX) ? value : value + BLOB_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/image_pass_scheduler_pixel_scan_counter.sv
// Raster scan counter for one image pass.
//   clock, reset_n : clock and asynchronous active-low reset
//   enable         : advance one pixel per cycle while high, hold otherwise
//   hcount, vcount : current pixel column / row, hcount runs fastest
//   last           : high on pixel (HSIZE-1, VSIZE-1) while enabled; the
//                    counters wrap to (0,0) on the following cycle
module pixel_scan_counter
    import image_pass_scheduler_pkg::*;
#(
    parameter int HSIZE = 512,
    parameter int VSIZE = 424
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    output logic [SCAN_W-1:0] hcount,
    output logic [SCAN_W-1:0] vcount,
    output logic              last
);

    localparam logic [SCAN_W-1:0] H_LAST = SCAN_W'(HSIZE - 1);
    localparam logic [SCAN_W-1:0] V_LAST = SCAN_W'(VSIZE - 1);

    logic [SCAN_W-1:0] hcount_q, hcount_d;
    logic [SCAN_W-1:0] vcount_q, vcount_d;
    logic              h_last;

    always_comb begin
        h_last   = (hcount_q == H_LAST);
        last     = enable && h_last && (vcount_q == V_LAST);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (enable) begin
            if (h_last) begin
                hcount_d = '0;
                // Wrapping at the frame end leaves the counters at (0,0),
                // ready for the next pass or for IDLE without a clear cycle.
                vcount_d = last ? '0 : vcount_q + SCAN_W'(1);
            end else begin
                hcount_d = hcount_q + SCAN_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount = hcount_q;
    assign vcount = vcount_q;

endmodule

// File: rtl/image_pass_scheduler.sv
// Sequences the image passes for one camera frame:
// LOAD -> ERODE -> DILATE -> BLOB (BLOB repeated until a blob is confirmed
// or MAX_BLOB_PASSES is reached), then reports the touch verdict.
//   clock, reset_n         : clock and asynchronous active-low reset
//   frame_available        : one-cycle pulse, a new frame is present
//   blob_valid             : datapath verdict, sampled on the last BLOB pixel
//   pass_kind              : current pass (pass_kind_e encoding)
//   hcount, vcount         : current pixel column / row
//   pass_start, pass_done  : first / last pixel cycle of a pass
//   busy                   : any pass in progress
//   blob_count             : BLOB passes completed in the current frame
//   touch, touch_ready     : frame verdict and its one-cycle update strobe
//   frame_dropped          : one-cycle pulse, a frame request was discarded
module image_pass_scheduler
    import image_pass_scheduler_pkg::*;
#(
    parameter int HSIZE           = 512,
    parameter int VSIZE           = 424,
    parameter int MAX_BLOB_PASSES = 20
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    frame_available,
    input  logic                    blob_valid,
    output logic [2:0]              pass_kind,
    output logic [SCAN_W-1:0]       hcount,
    output logic [SCAN_W-1:0]       vcount,
    output logic                    pass_start,
    output logic                    pass_done,
    output logic                    busy,
    output logic [BLOB_COUNT_W-1:0] blob_count,
    output logic                    touch,
    output logic                    touch_ready,
    output logic                    frame_dropped
);

    pass_kind_e                state_q, state_d;
    logic                      pending_q, pending_d;
    logic [BLOB_COUNT_W-1:0]   blob_count_q, blob_count_d;
    logic                      touch_q, touch_d;
    logic                      touch_ready_q, touch_ready_d;
    logic [BLOB_COUNT_W-1:0]   blob_inc;
    logic                      scan_last;

    pixel_scan_counter #(
        .HSIZE (HSIZE),
        .VSIZE (VSIZE)
    ) u_scan (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (busy),
        .hcount  (hcount),
        .vcount  (vcount),
        .last    (scan_last)
    );

    assign busy = (state_q != PASS_IDLE);

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        blob_count_d  = blob_count_q;
        touch_d       = touch_q;
        touch_ready_d = 1'b0;
        frame_dropped = 1'b0;
        blob_inc      = blob_count_inc(blob_count_q);

        // Requests arriving mid-frame are queued one deep; a second one is lost.
        if (busy && frame_available) begin
            if (pending_q) begin
                frame_dropped = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            PASS_IDLE: begin
                if (frame_available || pending_q) begin
                    state_d      = PASS_LOAD;
                    pending_d    = 1'b0;
                    blob_count_d = '0;
                end
            end
            PASS_LOAD: begin
                if (scan_last) state_d = PASS_ERODE;
            end
            PASS_ERODE: begin
                if (scan_last) state_d = PASS_DILATE;
            end
            PASS_DILATE: begin
                if (scan_last) state_d = PASS_BLOB;
            end
            PASS_BLOB: begin
                if (scan_last) begin
                    blob_count_d = blob_inc;
                    if (blob_valid) begin
                        touch_d       = 1'b1;
                        touch_ready_d = 1'b1;
                        state_d       = PASS_IDLE;
                    end else if (int'(blob_inc) >= MAX_BLOB_PASSES) begin
                        touch_d       = 1'b0;
                        touch_ready_d = 1'b1;
                        state_d       = PASS_IDLE;
                    end
                    // Otherwise stay in BLOB; the scan counter has already
                    // wrapped to (0,0) for the rerun.
                end
            end
            default: begin
                state_d = PASS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= PASS_IDLE;
            pending_q     <= 1'b0;
            blob_count_q  <= '0;
            touch_q       <= 1'b0;
            touch_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            blob_count_q  <= blob_count_d;
            touch_q       <= touch_d;
            touch_ready_q <= touch_ready_d;
        end
    end

    assign pass_kind   = state_q;
    assign pass_start  = busy && (hcount == '0) && (vcount == '0);
    assign pass_done   = scan_last;
    assign blob_count  = blob_count_q;
    assign touch       = touch_q;
    assign touch_ready = touch_ready_q;

endmodule
